// File: rtl/tx_pattern_pkg.sv
// Shared types and PRBS constants for the TX pattern controller.
// Ramping of the driver codes is enabled by defining TX_DRV_RAMP_EN.
package tx_pattern_pkg;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbs_mode_t;

    localparam int LFSR_W         = 31;
    localparam int DRV_SLICES_MAX = 40;

    localparam int PRBS7_ORD  = 7;
    localparam int PRBS7_TAP  = 6;
    localparam int PRBS15_ORD = 15;
    localparam int PRBS15_TAP = 14;
    localparam int PRBS23_ORD = 23;
    localparam int PRBS23_TAP = 18;
    localparam int PRBS31_ORD = 31;
    localparam int PRBS31_TAP = 28;

    // All-ones over the active order; doubles as the reseed value.
    function automatic logic [LFSR_W-1:0] prbs_mask(prbs_mode_t m);
        logic [LFSR_W-1:0] v;
        case (m)
            PRBS7:   v = 31'h0000_007F;
            PRBS15:  v = 31'h0000_7FFF;
            PRBS23:  v = 31'h007F_FFFF;
            default: v = 31'h7FFF_FFFF;
        endcase
        return v;
    endfunction

    function automatic logic prbs_fb(prbs_mode_t m, logic [LFSR_W-1:0] s);
        logic fb;
        case (m)
            PRBS7:   fb = s[PRBS7_ORD-1] ^ s[PRBS7_TAP-1];
            PRBS15:  fb = s[PRBS15_ORD-1] ^ s[PRBS15_TAP-1];
            PRBS23:  fb = s[PRBS23_ORD-1] ^ s[PRBS23_TAP-1];
            default: fb = s[PRBS31_ORD-1] ^ s[PRBS31_TAP-1];
        endcase
        return fb;
    endfunction

endpackage

// File: rtl/tx_drv_ramp.sv
// One driver side: clamp target, ramp (or follow) current code, thermometer.
// Ramping is compiled in only when TX_DRV_RAMP_EN is defined.
module tx_drv_ramp
    import tx_pattern_pkg::*;
#(
    parameter int DRV_BITS   = 6,
    parameter int DRV_SLICES = 40,
    parameter int RAMP_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DRV_BITS-1:0]   target,
    output logic [DRV_SLICES-1:0] ctl,
    output logic                  busy
);

    localparam int CW = $clog2(DRV_SLICES + 1);

    if (RAMP_DIV < 1 || RAMP_DIV > 255 || DRV_SLICES > DRV_SLICES_MAX) begin : g_cfg_err
        $error("tx_drv_ramp: parameter out of range");
    end

    logic [CW-1:0] cur;
    logic [CW-1:0] tgt;

    always_comb begin
        tgt = CW'(target);
        if (int'(target) > DRV_SLICES)
            tgt = CW'(DRV_SLICES);
    end

    always_comb begin
        ctl = '0;
        for (int i = 0; i < DRV_SLICES; i++)
            ctl[i] = (CW'(i) < cur);
    end

`ifdef TX_DRV_RAMP_EN
    logic [7:0] div;
    logic       step;

    assign step = (div == 8'(RAMP_DIV - 1));
    assign busy = (cur != tgt);

    // Divider free-runs so a retarget continues from the current code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            cur <= '0;
        end else begin
            div <= step ? '0 : div + 8'd1;
            if (step) begin
                if (cur < tgt)
                    cur <= cur + 1'b1;
                else if (cur > tgt)
                    cur <= cur - 1'b1;
            end
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur <= '0;
        else
            cur <= tgt;
    end
`endif

endmodule

// File: rtl/tx_pattern_ctrl.sv
// PRBS7/15/23/31 word generator with error injection and driver code control.
// Driver code ramping is enabled by defining TX_DRV_RAMP_EN.
module tx_pattern_ctrl
    import tx_pattern_pkg::*;
#(
    parameter int NLANES     = 16,
    parameter int DRV_BITS   = 6,
    parameter int DRV_SLICES = 40,
    parameter int RAMP_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  seed_load,
    input  logic                  inj_req,
    output logic                  inj_ack,
    input  logic [DRV_BITS-1:0]   drv_code_n,
    input  logic [DRV_BITS-1:0]   drv_code_p,
    output logic [NLANES-1:0]     dout,
    output logic [DRV_SLICES-1:0] ctl_n,
    output logic [DRV_SLICES-1:0] ctl_p,
    output logic                  ramp_busy
);

    prbs_mode_t        mode_q;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] s;
    logic [NLANES-1:0] word;
    logic              fb;
    logic              seed_pend;
    logic              inj_prev;
    logic              inj_pend;
    logic              inj_rise;
    logic              inj_now;
    logic              emit;
    logic              busy_n;
    logic              busy_p;

    always_comb begin
        s    = lfsr;
        word = '0;
        fb   = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            fb      = prbs_fb(mode_q, s);
            word[i] = fb;
            s       = {s[LFSR_W-2:0], fb} & prbs_mask(mode_q);
        end
        lfsr_nxt = s;
    end

    assign inj_rise = inj_req & ~inj_prev;
    assign inj_now  = inj_pend | inj_rise;
    assign emit     = en | seed_pend;

    // The flip goes only onto dout; the LFSR never sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= PRBS7;
            lfsr      <= '1;
            dout      <= '0;
            seed_pend <= 1'b0;
            inj_prev  <= 1'b1;
            inj_pend  <= 1'b0;
            inj_ack   <= 1'b0;
        end else begin
            inj_prev <= inj_req;
            inj_ack  <= inj_rise;
            if (seed_load) begin
                mode_q    <= prbs_mode_t'(mode);
                lfsr      <= prbs_mask(prbs_mode_t'(mode));
                seed_pend <= 1'b1;
                inj_pend  <= inj_now;
            end else if (emit) begin
                lfsr      <= lfsr_nxt;
                dout      <= word ^ {{(NLANES-1){1'b0}}, inj_now};
                seed_pend <= 1'b0;
                inj_pend  <= 1'b0;
            end else begin
                inj_pend  <= inj_now;
            end
        end
    end

    tx_drv_ramp #(
        .DRV_BITS   (DRV_BITS),
        .DRV_SLICES (DRV_SLICES),
        .RAMP_DIV   (RAMP_DIV)
    ) u_ramp_n (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (drv_code_n),
        .ctl    (ctl_n),
        .busy   (busy_n)
    );

    tx_drv_ramp #(
        .DRV_BITS   (DRV_BITS),
        .DRV_SLICES (DRV_SLICES),
        .RAMP_DIV   (RAMP_DIV)
    ) u_ramp_p (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (drv_code_p),
        .ctl    (ctl_p),
        .busy   (busy_p)
    );

    assign ramp_busy = busy_n | busy_p;

endmodule

// File: tb/tb_tx_pattern_ctrl.sv
// Directed bench for tx_pattern_ctrl: PRBS words, injection, ramp, reset.
// Builds with or without TX_DRV_RAMP_EN.
`timescale 1ns/1ps
module tb_tx_pattern_ctrl;

    localparam logic [63:0] ONES40 = 64'h00FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        seed_load;
    logic        inj_req;
    logic        inj_ack;
    logic [5:0]  drv_code_n;
    logic [5:0]  drv_code_p;
    logic [15:0] dout;
    logic [39:0] ctl_n;
    logic [39:0] ctl_p;
    logic        ramp_busy;

    tx_pattern_ctrl #(
        .NLANES     (16),
        .DRV_BITS   (6),
        .DRV_SLICES (40),
        .RAMP_DIV   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .seed_load  (seed_load),
        .inj_req    (inj_req),
        .inj_ack    (inj_ack),
        .drv_code_n (drv_code_n),
        .drv_code_p (drv_code_p),
        .dout       (dout),
        .ctl_n      (ctl_n),
        .ctl_p      (ctl_p),
        .ramp_busy  (ramp_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Recurrence model: e[t] = e[t-n] ^ e[t-k], history seeded with ones.
    bit ring [64];
    int mt, mn, mk;

    task automatic model_seed(input int m);
        case (m)
            0:       begin mn = 7;  mk = 6;  end
            1:       begin mn = 15; mk = 14; end
            2:       begin mn = 23; mk = 18; end
            default: begin mn = 31; mk = 28; end
        endcase
        foreach (ring[i]) ring[i] = 1'b1;
        mt = 64;
    endtask

    task automatic model_word(output logic [15:0] w);
        bit b;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            b = ring[(mt - mn) % 64] ^ ring[(mt - mk) % 64];
            ring[mt % 64] = b;
            w[i] = b;
            mt++;
        end
    endtask

    logic [15:0] exp_w, first_w, last_w;
    int  run_len, max1, max0, pc, prev, nchg, last_chg, hit;
    bit  run_val;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; seed_load = 1'b0;
        inj_req = 1'b0; drv_code_n = '0; drv_code_p = '0;
        tick();
        tick();
        chk("rst_dout", dout, 0);
        chk("rst_ack", inj_ack, 0);
        chk("rst_ctl_n", ctl_n, 0);
        chk("rst_ctl_p", ctl_p, 0);
        chk("rst_busy", ramp_busy, 0);
        rst_n = 1'b1;
        tick();

        // PRBS7; mode input changed afterwards must be ignored
        mode = 2'd0; seed_load = 1'b1;
        tick();
        chk("seed_edge_hold", dout, 0);
        seed_load = 1'b0; en = 1'b1; mode = 2'd2;
        model_seed(0);
        for (int w = 0; w < 140; w++) begin
            tick();
            model_word(exp_w);
            if (w == 0) first_w = exp_w;
            chk("prbs7", dout, exp_w ^ 16'((w == 50) ? 1 : 0));
            chk("prbs7_ack", inj_ack, (w == 50) ? 1 : 0);
            if (w == 127) chk("prbs7_period", dout, first_w);
            if (w == 49) inj_req = 1'b1;
            if (w == 59) inj_req = 1'b0;
            last_w = exp_w;
        end

        // freeze with a pending injection
        en = 1'b0; inj_req = 1'b1;
        tick();
        chk("frz_ack", inj_ack, 1);
        chk("frz_dout0", dout, last_w);
        tick();
        chk("frz_ack_once", inj_ack, 0);
        chk("frz_dout1", dout, last_w);
        en = 1'b1;
        tick();
        model_word(exp_w);
        chk("pend_inj", dout, exp_w ^ 16'h1);
        tick();
        model_word(exp_w);
        chk("post_inj", dout, exp_w);
        inj_req = 1'b0; en = 1'b0;
        tick();

        // reseed to PRBS15 with coincident injection, en low
        mode = 2'd1; seed_load = 1'b1; inj_req = 1'b1;
        tick();
        chk("seed_inj_ack", inj_ack, 1);
        seed_load = 1'b0;
        model_seed(1);
        tick();
        model_word(exp_w);
        chk("p15_first_inj", dout, exp_w ^ 16'h1);
        tick();
        chk("p15_frozen", dout, exp_w ^ 16'h1);
        en = 1'b1; inj_req = 1'b0;
        for (int w = 0; w < 30; w++) begin
            tick();
            model_word(exp_w);
            chk("prbs15", dout, exp_w);
        end

        // PRBS23 with en held high across the seed edge
        mode = 2'd2; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_seed(2);
        for (int w = 0; w < 30; w++) begin
            tick();
            model_word(exp_w);
            chk("prbs23", dout, exp_w);
        end

        // PRBS31 long run; run tracking starts inside the 31-one seed
        mode = 2'd3; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_seed(3);
        run_val = 1'b1; run_len = 31; max1 = 31; max0 = 0;
        for (int w = 0; w < 65536; w++) begin
            tick();
            model_word(exp_w);
            chk("prbs31", dout, exp_w);
            for (int i = 0; i < 16; i++) begin
                if (dout[i] == run_val) run_len++;
                else begin run_val = dout[i]; run_len = 1; end
                if (run_val && run_len > max1) max1 = run_len;
                if (!run_val && run_len > max0) max0 = run_len;
            end
        end
        chk("p31_max_ones", max1, 31);
        chk("p31_zeros_lt32", (max0 < 32) ? 1 : 0, 1);

`ifdef TX_DRV_RAMP_EN
        drv_code_p = 6'd40;
        prev = 0; nchg = 0; last_chg = -1;
        for (int c = 1; c <= 170; c++) begin
            tick();
            pc = $countones(ctl_p);
            if (pc != prev) begin
                chk("p_step", pc, prev + 1);
                if (last_chg >= 0) chk("p_gap", c - last_chg, 4);
                last_chg = c; nchg++; prev = pc;
            end
            if (c == 80) chk("p_busy_mid", ramp_busy, 1);
        end
        chk("p_full", ctl_p, ONES40);
        chk("p_nchg", nchg, 40);
        chk("p_by_160", (last_chg <= 160) ? 1 : 0, 1);
        chk("p_busy_end", ramp_busy, 0);

        drv_code_n = 6'd63;
        hit = 0;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            tick();
            if ($countones(ctl_n) == 20) hit = 1;
        end
        chk("n_reach20", hit, 1);
        drv_code_n = 6'd10;
        prev = 20; nchg = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            pc = $countones(ctl_n);
            if (pc != prev) begin
                chk("n_down", pc, prev - 1);
                prev = pc; nchg++;
            end
        end
        chk("n_at10", ctl_n, 64'h3FF);
        chk("n_nchg", nchg, 10);
        chk("n_busy_10", ramp_busy, 0);
        drv_code_n = 6'd63;
        for (int c = 0; c < 130; c++) tick();
        chk("n_clamp", ctl_n, ONES40);
        chk("n_clamp_busy", ramp_busy, 0);
`else
        drv_code_p = 6'd40;
        tick();
        chk("p_follow", ctl_p, ONES40);
        chk("p_busy0", ramp_busy, 0);
        drv_code_n = 6'd63;
        tick();
        chk("n_clamp", ctl_n, ONES40);
        chk("n_busy0", ramp_busy, 0);
        drv_code_n = 6'd10;
        tick();
        chk("n_follow", ctl_n, 64'h3FF);
`endif

        // reset mid-ramp and mid-pattern, inj_req high across release
        drv_code_p = 6'd10;
        for (int c = 0; c < 12; c++) tick();
        inj_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_ctl_n", ctl_n, 0);
        chk("mid_rst_ctl_p", ctl_p, 0);
        chk("mid_rst_ack", inj_ack, 0);
        tick();
        rst_n = 1'b1; mode = 2'd0; seed_load = 1'b1;
        tick();
        chk("rel_no_ack", inj_ack, 0);
        seed_load = 1'b0;
        model_seed(0);
        for (int w = 0; w < 20; w++) begin
            tick();
            model_word(exp_w);
            chk("restart_p7", dout, exp_w);
            chk("restart_ack", inj_ack, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
